// File: rtl/interconnect_pkg.sv
// Shared widths and constants for the global-memory crossbar and the PE-side load/store initiator.
// No logic; constants and types only.
// Store-buffer state type and default queue depths live here too.
package interconnect_pkg;

    // Global address = {bank id, word address within bank}
    localparam int GLOBAL_MEM_PER_BANK_ADDR_L = 10;
    localparam int BANK_ID_L                  = 2;
    localparam int GLOBAL_MEM_ADDR_L          = GLOBAL_MEM_PER_BANK_ADDR_L + BANK_ID_L;
    localparam int DATA_L                     = 16;
    localparam int BANK_ADDR_START            = 0;
    localparam int BANK_ID_START              = GLOBAL_MEM_PER_BANK_ADDR_L;

    // Default depths for the initiator queues
    localparam int LD_Q_DEPTH_DEF = 4;
    localparam int RSP_DEPTH_DEF  = 4;

    // Single-entry store buffer
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } st_buf_state_e;

endpackage

// File: rtl/pe_ldst_fifo.sv
// Synchronous FIFO, parameterized width and power-of-2 depth, with occupancy count.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: push while full and pop while empty are ignored; pop_data reads 0 when empty.
module pe_ldst_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally for power-of-2 depth
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage array; contents need no reset because empty masks the head
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pe_ldst_initiator.sv
// Per-PE load/store initiator: queues core loads/stores and drives the PE's ld/st lanes to the crossbar.
// Latency: command accepted at t -> request at t+1; ld_data_vld at t -> core_rsp_vld at t+1.
// Backpressure: requests held until granted; loads issue only with a free response slot (credit).
// Option: define PE_LDST_RAW_CHECK_EN to stall a load hitting the word of a pending store.
module pe_ldst_initiator
    import interconnect_pkg::*;
#(
    parameter int PE_ID      = 0,
    parameter int LD_Q_DEPTH = LD_Q_DEPTH_DEF,
    parameter int RSP_DEPTH  = RSP_DEPTH_DEF
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  core_ld_vld,
    input  logic [GLOBAL_MEM_ADDR_L-1:0]          core_ld_addr,
    output logic                                  core_ld_rdy,
    input  logic                                  core_st_vld,
    input  logic [GLOBAL_MEM_PER_BANK_ADDR_L-1:0] core_st_addr,
    input  logic [DATA_L-1:0]                     core_st_data,
    output logic                                  core_st_rdy,
    output logic                                  core_rsp_vld,
    output logic [DATA_L-1:0]                     core_rsp_data,
    input  logic                                  core_rsp_rdy,
    output logic [GLOBAL_MEM_ADDR_L-1:0]          ld_addr,
    output logic                                  ld_req,
    input  logic                                  ld_gnt,
    input  logic [DATA_L-1:0]                     ld_data,
    input  logic                                  ld_data_vld,
    output logic [GLOBAL_MEM_PER_BANK_ADDR_L-1:0] st_addr,
    output logic [DATA_L-1:0]                     st_data,
    output logic                                  st_req,
    input  logic                                  st_gnt,
    output logic                                  err_unexpected_rsp
);

    localparam int CW = $clog2(RSP_DEPTH) + 1;
    localparam int SW = CW + 1;

    logic [GLOBAL_MEM_ADDR_L-1:0]  ld_head;
    logic [$clog2(LD_Q_DEPTH):0]   ld_q_count;
    logic                          ld_q_full;
    logic                          ld_q_empty;
    logic [CW-1:0]                 rsp_count;
    logic                          rsp_full;
    logic                          rsp_empty;
    logic [CW-1:0]                 inflight;
    logic                          credit_ok;
    logic                          raw_block;
    logic                          ld_issue;
    logic                          rsp_accept;
    logic                          rsp_unexpected;
    st_buf_state_e                 st_state;
    st_buf_state_e                 st_state_nxt;
    logic                          st_accept;
    logic                          unused_ok;

    assign unused_ok = &{1'b0, ld_q_count, rsp_full};

    // ---------------- load path ----------------
    pe_ldst_fifo #(
        .WIDTH (GLOBAL_MEM_ADDR_L),
        .DEPTH (LD_Q_DEPTH)
    ) u_ld_q (
        .clk       (clk),
        .rst       (rst),
        .push      (core_ld_vld & core_ld_rdy),
        .push_data (core_ld_addr),
        .pop       (ld_issue),
        .pop_data  (ld_head),
        .count     (ld_q_count),
        .full      (ld_q_full),
        .empty     (ld_q_empty)
    );

    assign core_ld_rdy = ~ld_q_full;

    // Every issued load must have a guaranteed response slot
    assign credit_ok = (SW'(inflight) + SW'(rsp_count)) < SW'(RSP_DEPTH);

`ifdef PE_LDST_RAW_CHECK_EN
    assign raw_block = (st_state == ST_FULL)
                     && (ld_head[BANK_ID_START +: BANK_ID_L] == BANK_ID_L'(PE_ID))
                     && (ld_head[BANK_ADDR_START +: GLOBAL_MEM_PER_BANK_ADDR_L] == st_addr);
`else
    assign raw_block = 1'b0;
`endif

    assign ld_req         = ~ld_q_empty & credit_ok & ~raw_block;
    assign ld_addr        = ld_head;
    assign ld_issue       = ld_req & ld_gnt;
    assign rsp_accept     = ld_data_vld & (inflight != '0);
    assign rsp_unexpected = ld_data_vld & (inflight == '0);

    // Outstanding-load counter: +1 per grant, -1 per accepted return word
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({ld_issue, rsp_accept})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // Sticky flag for return data nobody asked for
    always_ff @(posedge clk) begin
        if (rst) begin
            err_unexpected_rsp <= 1'b0;
        end else if (rsp_unexpected) begin
            err_unexpected_rsp <= 1'b1;
        end
    end

    // ---------------- response path ----------------
    pe_ldst_fifo #(
        .WIDTH (DATA_L),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_q (
        .clk       (clk),
        .rst       (rst),
        .push      (rsp_accept),
        .push_data (ld_data),
        .pop       (core_rsp_vld & core_rsp_rdy),
        .pop_data  (core_rsp_data),
        .count     (rsp_count),
        .full      (rsp_full),
        .empty     (rsp_empty)
    );

    assign core_rsp_vld = ~rsp_empty;

    // ---------------- store path ----------------
    assign core_st_rdy = (st_state == ST_EMPTY);
    assign st_req      = (st_state == ST_FULL);
    assign st_accept   = core_st_vld & (st_state == ST_EMPTY);

    // Store buffer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            st_state <= ST_EMPTY;
        end else begin
            st_state <= st_state_nxt;
        end
    end

    // Store buffer next state: fill on command, drain on grant
    always_comb begin
        st_state_nxt = st_state;
        case (st_state)
            ST_EMPTY: if (core_st_vld) st_state_nxt = ST_FULL;
            ST_FULL:  if (st_gnt)      st_state_nxt = ST_EMPTY;
            default:                   st_state_nxt = ST_EMPTY;
        endcase
    end

    // Capture store address/data on accept; held unchanged while the buffer is full
    always_ff @(posedge clk) begin
        if (rst) begin
            st_addr <= '0;
            st_data <= '0;
        end else if (st_accept) begin
            st_addr <= core_st_addr;
            st_data <= core_st_data;
        end
    end

endmodule
